// File: rtl/onehot_drain_encoder_if.sv
// Load/drain handshake bundle for onehot_drain_encoder.
// The remaining-count signal exists only when ONEHOT_DRAIN_ENCODER_COUNT_EN is defined.
interface onehot_drain_encoder_if #(
    parameter int WIDTH = 128,
    parameter int IDX_W = 7
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_vec;
    logic             idx_valid;
    logic             idx_ready;
    logic [IDX_W-1:0] idx;
    logic             idx_last;
    logic             busy;
`ifdef ONEHOT_DRAIN_ENCODER_COUNT_EN
    logic [IDX_W:0]   remaining;
`endif

    // master = vector producer / index consumer side; slave = the encoder
    modport master (
        output load_valid, load_vec, idx_ready,
        input  load_ready, idx_valid, idx, idx_last, busy
`ifdef ONEHOT_DRAIN_ENCODER_COUNT_EN
        , input remaining
`endif
    );

    modport slave (
        input  load_valid, load_vec, idx_ready,
        output load_ready, idx_valid, idx, idx_last, busy
`ifdef ONEHOT_DRAIN_ENCODER_COUNT_EN
        , output remaining
`endif
    );
endinterface

// File: rtl/onehot_drain_encoder.sv
// Turns a WIDTH-bit mask into a stream of set-bit indices, lowest first, one per handshake.
// Optional ONEHOT_DRAIN_ENCODER_COUNT_EN adds a remaining-index counter.
module onehot_drain_encoder #(
    parameter int WIDTH = 128,
    parameter int IDX_W = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    onehot_drain_encoder_if.slave  bus
);
    typedef enum logic {IDLE, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] enc_in;
    logic [WIDTH-1:0] enc_rest;
    logic [IDX_W-1:0] enc_idx;
    logic [IDX_W-1:0] idx_q;
    logic             idx_valid_q;
    logic             idx_last_q;
    logic             load_acc;
    logic             load_nz;
    logic             hs;

    assign load_acc = bus.load_valid & bus.load_ready;
    assign load_nz  = |bus.load_vec;
    assign hs       = idx_valid_q & bus.idx_ready;

    // Single shared encoder: fed by the incoming vector in IDLE, by the leftover mask in DRAIN.
    assign enc_in = (state == IDLE) ? bus.load_vec : pending;

    always_comb begin
        enc_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (enc_in[i]) enc_idx = IDX_W'(i);
    end

    // x & (x-1) drops the lowest set bit
    assign enc_rest = enc_in & (enc_in - WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_acc && load_nz) state_nxt = DRAIN;
            DRAIN:   if (hs && pending == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.load_ready = (state == IDLE);
        bus.busy       = (state == DRAIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending     <= '0;
            idx_q       <= '0;
            idx_last_q  <= 1'b0;
            idx_valid_q <= 1'b0;
        end else if (state == IDLE) begin
            if (load_acc && load_nz) begin
                idx_q       <= enc_idx;
                pending     <= enc_rest;
                idx_last_q  <= (enc_rest == '0);
                idx_valid_q <= 1'b1;
            end
        end else if (hs) begin
            if (pending != '0) begin
                idx_q      <= enc_idx;
                pending    <= enc_rest;
                idx_last_q <= (enc_rest == '0);
            end else begin
                // idx keeps its final value after the drain completes
                idx_valid_q <= 1'b0;
                idx_last_q  <= 1'b0;
            end
        end
    end

    assign bus.idx       = idx_q;
    assign bus.idx_valid = idx_valid_q;
    assign bus.idx_last  = idx_last_q;

`ifdef ONEHOT_DRAIN_ENCODER_COUNT_EN
    logic [IDX_W:0] popcnt;
    logic [IDX_W:0] remaining_q;

    always_comb begin
        popcnt = '0;
        for (int i = 0; i < WIDTH; i++)
            popcnt = popcnt + (IDX_W + 1)'(bus.load_vec[i]);
    end

    // Reaches zero on the final handshake, so IDLE always reads 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  remaining_q <= '0;
        else if (state == IDLE && load_acc && load_nz) remaining_q <= popcnt;
        else if (state == DRAIN && hs)            remaining_q <= remaining_q - 1'b1;
    end

    assign bus.remaining = remaining_q;
`endif
endmodule

// File: tb/tb_onehot_drain_encoder.sv
// Self-checking bench for onehot_drain_encoder: directed plan steps plus random masks
// compared against a queue-of-set-indices reference model.
module tb_onehot_drain_encoder;
    localparam int W  = 128;
    localparam int IW = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    onehot_drain_encoder_if #(.WIDTH(W), .IDX_W(IW)) bus ();

    onehot_drain_encoder #(.WIDTH(W), .IDX_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_idx_valid"},  32'(bus.idx_valid),  32'd0);
        chk({tag, "_idx_last"},   32'(bus.idx_last),   32'd0);
        chk({tag, "_busy"},       32'(bus.busy),       32'd0);
        chk({tag, "_load_ready"}, 32'(bus.load_ready), 32'd1);
`ifdef ONEHOT_DRAIN_ENCODER_COUNT_EN
        chk({tag, "_remaining"},  32'(bus.remaining),  32'd0);
`endif
    endtask

    // Load v, then drain it. rdy_pct: chance idx_ready is high; hold: forced stall
    // cycles at the first index; abort_at: handshake count at which rst is pulsed (-1 = never).
    task automatic run_vec(input string tag, input logic [W-1:0] v, input int rdy_pct,
                           input int hold, input int abort_at);
        int   q[$];
        int   hs_cnt = 0;
        int   cyc = 0;
        int   stalls = 0;
        logic rdy;
        logic [W-1:0] junk;
        for (int i = 0; i < W; i++) if (v[i]) q.push_back(i);

        @(negedge clk);
        chk({tag, "_pre_load_ready"}, 32'(bus.load_ready), 32'd1);
        bus.load_valid = 1'b1;
        bus.load_vec   = v;
        bus.idx_ready  = 1'b0;
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.load_vec   = '0;

        while (q.size() > 0) begin
            if (cyc++ > 4000) begin
                chk({tag, "_drain_timeout"}, 32'(q.size()), 32'd0);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (hs_cnt == abort_at) begin
                #2 rst = 1'b1;
                #1;
                chk({tag, "_abort_idx"}, 32'(bus.idx), 32'd0);
                chk_idle({tag, "_abort"});
                @(negedge clk);
                rst = 1'b0;
                bus.idx_ready = 1'b0;
                return;
            end
            chk({tag, "_idx_valid"},  32'(bus.idx_valid),  32'd1);
            chk({tag, "_idx"},        32'(bus.idx),        32'(q[0]));
            chk({tag, "_idx_last"},   32'(bus.idx_last),   32'(q.size() == 1));
            chk({tag, "_busy"},       32'(bus.busy),       32'd1);
            chk({tag, "_load_ready"}, 32'(bus.load_ready), 32'd0);
`ifdef ONEHOT_DRAIN_ENCODER_COUNT_EN
            chk({tag, "_remaining"},  32'(bus.remaining),  32'(q.size()));
`endif
            rdy = ($urandom_range(0, 99) < rdy_pct);
            if (stalls < hold) begin
                rdy = 1'b0;
                stalls++;
            end
            bus.idx_ready  = rdy;
            // loads offered mid-drain must be ignored
            junk           = {$urandom, $urandom, $urandom, $urandom};
            bus.load_vec   = junk;
            bus.load_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (rdy) begin
                void'(q.pop_front());
                hs_cnt++;
            end
        end
        bus.idx_ready  = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_vec   = '0;
        chk_idle({tag, "_done"});
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(0, 3))
            0: begin v = '0; v[$urandom_range(0, W - 1)] = 1'b1; end
            1: v = a & b & {$urandom, $urandom, $urandom, $urandom};
            2: v = a | b;
            default: begin v = a & b; v[W - 1] = 1'b1; end
        endcase
        return v;
    endfunction

    initial begin
        logic [W-1:0] v;

        bus.load_valid = 1'b0;
        bus.load_vec   = '0;
        bus.idx_ready  = 1'b0;

        // 1. reset held for 2 cycles
        repeat (2) @(negedge clk);
        chk("rst_idx", 32'(bus.idx), 32'd0);
        chk("rst_valid", 32'(bus.idx_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_load_ready_in_rst", 32'(bus.load_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("after_rst");

        // 2. bits {0,5,127}, always ready
        v = '0; v[0] = 1'b1; v[5] = 1'b1; v[127] = 1'b1;
        run_vec("t2", v, 100, 0, -1);

        // 3. bits {3,64}, 3 stall cycles on the first index
        v = '0; v[3] = 1'b1; v[64] = 1'b1;
        run_vec("t3", v, 100, 3, -1);

        // 4. zero vector is swallowed
        run_vec("t4", '0, 100, 0, -1);
        @(negedge clk);
        chk_idle("t4_later");

        // 5. all ones
        v = '1;
        run_vec("t5", v, 100, 0, -1);

        // 6. abort after two handshakes, then a single-bit vector
        v = '0; v[10] = 1'b1; v[20] = 1'b1; v[30] = 1'b1;
        run_vec("t6", v, 100, 0, 2);
        @(negedge clk);
        chk_idle("t6_post_rst");
        v = '0; v[7] = 1'b1;
        run_vec("t6b", v, 100, 0, -1);

        // random masks with random backpressure
        for (int n = 0; n < 24; n++) begin
            v = rand_vec();
            run_vec("rnd", v, 60, 0, -1);
        end
        run_vec("rnd_abort", rand_vec() | 128'h3, 70, 0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/onehot_drain_encoder.md
Name: onehot_drain_encoder

Overview:
- Inverse of the 7-to-128 one-hot decoder used in the cache/regfile select paths.
- Accepts a 128-bit bit-vector (e.g. valid/dirty/ready masks) and emits the 7-bit index of every set bit, one per handshake, lowest index first.
- Used for writeback/flush sequencing and wakeup draining, where a mask must be turned back into a stream of encoded indices.

Parameters:
WIDTH, 128, vector width; power of two, at least 2.
IDX_W, 7, index width; must equal log2(WIDTH).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-high.
load_valid  in  1  load_vec is presented.
load_ready  out  1  block accepts a vector; high only in IDLE.
load_vec  in  WIDTH  bit-vector to drain.
idx_valid  out  1  idx is valid.
idx_ready  in  1  consumer takes idx this cycle.
idx  out  IDX_W  encoded index of the current set bit.
idx_last  out  1  idx is the final set bit of the vector.
busy  out  1  high in DRAIN.

Behaviour:
- Reset (async, immediate on rst rising):
  - state = IDLE, pending = 0.
  - idx_valid = 0, idx = 0, idx_last = 0, busy = 0.
  - load_ready = 1 while rst is low and state is IDLE.
- States: IDLE and DRAIN. load_ready = (state == IDLE); busy = (state == DRAIN).
- Priority encode: lowest set bit of a vector, as an IDX_W-bit binary index. Combinational, one instance. No multiple-driver or casez shortcuts that would leave idx undefined for any input.
- IDLE, load accept (load_valid & load_ready):
  - load_vec == 0: vector consumed and discarded. No output. Stay in IDLE.
  - Otherwise, at the next edge:
    - idx <= lowest set bit of load_vec.
    - pending <= load_vec with that bit cleared.
    - idx_last <= (that cleared vector == 0).
    - idx_valid <= 1, state <= DRAIN.
  - Latency: idx_valid is high one cycle after the accept edge.
- DRAIN, handshake (idx_valid & idx_ready):
  - pending != 0: idx <= lowest(pending), pending clears that bit, idx_last recomputed the same way. idx_valid stays 1, so back-to-back handshakes give one index per cycle.
  - pending == 0 (idx_last was 1): idx_valid <= 0, idx_last <= 0, state <= IDLE. idx holds its last value.
- Backpressure: while idx_valid & !idx_ready, idx, idx_last and pending hold stable.
- A new load is accepted no earlier than the cycle after the final handshake (one bubble). load_valid during DRAIN is ignored.
- Single-bit vector: first idx has idx_last = 1; returns to IDLE after one handshake.
- Bit WIDTH-1 encodes to all-ones with no wrap or sign issues.
- A rst assertion during DRAIN aborts the drain. Outputs return to reset values without waiting for a clock edge.

Optional Feature:
- Macro: ONEHOT_DRAIN_ENCODER_COUNT_EN.
- Defined:
  - Adds output remaining [IDX_W:0] = number of set bits not yet handshaken, including the current idx.
  - Loaded with popcount(load_vec) on accept; decrements by 1 on each handshake; 0 in IDLE and on reset.
  - An all-ones 128-bit vector loads 128.
- Undefined: port and popcount logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold rst 2 cycles -> idx_valid=0, idx=0, idx_last=0, busy=0, load_ready=1. Assert rst asynchronously mid-cycle -> outputs clear before the next edge.
2. Load bits {0,5,127} with idx_ready=1 -> idx=0, 5, 127 on 3 consecutive cycles; idx_last=1 only with 127; load_ready=1 the cycle after the third handshake.
3. Load bits {3,64}; drop idx_ready for 3 cycles while idx=3 -> idx=3, idx_valid=1, idx_last=0 held stable; after release, idx=64 with idx_last=1.
4. Load 0 -> accepted (load_ready stays 1), idx_valid never asserts, busy stays 0.
5. Load all-ones, idx_ready=1 -> 128 consecutive indices 0..127, idx_last on 127 only. With COUNT_EN, remaining = 128 on the first index and 1 on the last.
6. Load bits {10,20,30}; assert rst after the second handshake -> idx_valid=0, busy=0 immediately. Then load bit {7} -> single idx=7 with idx_last=1.
